// File: rtl/loop_counter_3d_if.sv
// Control and count bus of the three-level nested loop counter.
// Combinational bundle only. The counter registers every output.
// No backpressure. The master drives the controls and the slave drives the counts and flags.
interface loop_counter_3d_if #(
  parameter int CW = 8
);
  // Controls from the sequencer.
  logic          user_reset;
  logic          i_start;
  logic [CW-1:0] i_lim0;
  logic [CW-1:0] i_lim1;
  logic [CW-1:0] i_lim2;
  logic [CW-1:0] i_step0;
  logic          ce;

  // Counts and status from the counter.
  logic [CW-1:0] o_cnt0;
  logic [CW-1:0] o_cnt1;
  logic [CW-1:0] o_cnt2;
  logic          o_busy;
  logic          o_last;
  logic          o_done;

  modport master (
    output user_reset, i_start, i_lim0, i_lim1, i_lim2, i_step0, ce,
    input  o_cnt0, o_cnt1, o_cnt2, o_busy, o_last, o_done
  );

  modport slave (
    input  user_reset, i_start, i_lim0, i_lim1, i_lim2, i_step0, ce,
    output o_cnt0, o_cnt1, o_cnt2, o_busy, o_last, o_done
  );
endinterface

// File: rtl/loop_counter_3d.sv
// Three-level nested loop counter with a run-time latched limit and inner stride, for the address generators.
// Latency 1. The counts update on the edge that samples ce, and o_last follows the final advance by one cycle.
// No backpressure. ce is a plain advance request that is honoured only while running and is ignored in IDLE.
module loop_counter_3d #(
  parameter int CW = 8
) (
  input  logic              clk,
  input  logic              global_rst,
  input  logic              rst,
  loop_counter_3d_if.slave  bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Architectural state.
  state_t        state_q, state_d;
  logic [CW-1:0] lim0_q, lim0_d;
  logic [CW-1:0] lim1_q, lim1_d;
  logic [CW-1:0] lim2_q, lim2_d;
  logic [CW-1:0] step_q, step_d;
  logic [CW-1:0] cnt0_q, cnt0_d;
  logic [CW-1:0] cnt1_q, cnt1_d;
  logic [CW-1:0] cnt2_q, cnt2_d;
  logic          last_q, last_d;
  logic          done_q, done_d;

  // Advance datapath.
  logic          advance;
  logic [CW:0]   sum0;
  logic          carry0;
  logic          carry1;
  logic          carry2;
  logic [CW-1:0] nxt0;
  logic [CW-1:0] nxt1;
  logic [CW-1:0] nxt2;
  logic          final_adv;
  logic [CW-1:0] step_in;

  // A zero stride would stall the inner level forever, so it is stored as 1.
  assign step_in = (bus.i_step0 == '0) ? {{(CW-1){1'b0}}, 1'b1} : bus.i_step0;

  // A real advance needs RUN with ce, and it is blocked by a clear or a restart on the same edge.
  assign advance = (state_q == ST_RUN) && bus.ce && !rst && !bus.i_start;

  // Ripple the carry through the three levels. The inner sum gets one spare bit so a large stride cannot wrap past lim0.
  always_comb begin
    sum0   = {1'b0, cnt0_q} + {1'b0, step_q};
    carry0 = (sum0 > {1'b0, lim0_q});
    nxt0   = carry0 ? '0 : sum0[CW-1:0];

    carry1 = 1'b0;
    nxt1   = cnt1_q;
    if (carry0) begin
      if (cnt1_q == lim1_q) begin
        nxt1   = '0;
        carry1 = 1'b1;
      end else begin
        nxt1   = cnt1_q + 1'b1;
      end
    end

    carry2 = 1'b0;
    nxt2   = cnt2_q;
    if (carry1) begin
      if (cnt2_q == lim2_q) begin
        nxt2   = '0;
        carry2 = 1'b1;
      end else begin
        nxt2   = cnt2_q + 1'b1;
      end
    end
  end

  // The loop nest is exhausted when a carry leaves the outer level.
  assign final_adv = advance && carry2;

  // Next-state selection with priority rst, then i_start, then advance. The sticky done flag is resolved in parallel.
  always_comb begin
    state_d = state_q;
    lim0_d  = lim0_q;
    lim1_d  = lim1_q;
    lim2_d  = lim2_q;
    step_d  = step_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    cnt2_d  = cnt2_q;
    last_d  = 1'b0;

    if (rst) begin
      state_d = ST_IDLE;
      cnt0_d  = '0;
      cnt1_d  = '0;
      cnt2_d  = '0;
    end else if (bus.i_start) begin
      state_d = ST_RUN;
      lim0_d  = bus.i_lim0;
      lim1_d  = bus.i_lim1;
      lim2_d  = bus.i_lim2;
      step_d  = step_in;
      cnt0_d  = '0;
      cnt1_d  = '0;
      cnt2_d  = '0;
    end else if (advance) begin
      cnt0_d = nxt0;
      cnt1_d = nxt1;
      cnt2_d = nxt2;
      if (final_adv) begin
        state_d = ST_IDLE;
        last_d  = 1'b1;
      end
    end

    // If user_reset coincides with the final advance, the set wins.
    done_d = done_q;
    if (bus.user_reset) begin
      done_d = 1'b0;
    end
    if (final_adv) begin
      done_d = 1'b1;
    end
  end

  // Register all state. global_rst clears everything without a clock.
  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      state_q <= ST_IDLE;
      lim0_q  <= '0;
      lim1_q  <= '0;
      lim2_q  <= '0;
      step_q  <= {{(CW-1){1'b0}}, 1'b1};
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lim0_q  <= lim0_d;
      lim1_q  <= lim1_d;
      lim2_q  <= lim2_d;
      step_q  <= step_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  // Every output comes straight from a flop.
  assign bus.o_cnt0 = cnt0_q;
  assign bus.o_cnt1 = cnt1_q;
  assign bus.o_cnt2 = cnt2_q;
  assign bus.o_busy = (state_q == ST_RUN);
  assign bus.o_last = last_q;
  assign bus.o_done = done_q;

endmodule
